// File: rtl/irq_sysid_checker.sv
// ---------------------------------------------------------------------------
// irq_sysid_checker
//
// Reads the two words of an Avalon-MM system-ID slave (address 0 = ID,
// address 1 = build timestamp), compares them against the values this build
// expects, and reports the verdict. Each read is guarded by a cycle budget.
// If an access overruns that budget, the whole two-word sequence restarts,
// up to a fixed number of retries.
//
// Ports
//   clock              system clock, all state on the rising edge
//   reset              synchronous, active-high reset
//   start              one-cycle request to run a check (ignored while busy)
//   avm_address        read address (0 = ID word, 1 = timestamp word)
//   avm_read           read strobe, only ever high in RD_ID / RD_TS
//   avm_waitrequest    slave stall; command is held while high
//   avm_readdatavalid  read data valid (only looked at in WT_ID / WT_TS)
//   avm_readdata       32-bit read data
//   busy               check in progress
//   done               check finished; held until the next accepted start
//   pass               both words matched (meaningful while done = 1)
//   err_code           0 ok, 1 timeout, 2 ID mismatch, 3 timestamp mismatch
//   id_value           last captured ID word
//   ts_value           last captured timestamp word
// ---------------------------------------------------------------------------
module irq_sysid_checker #(
  parameter logic [31:0] EXP_ID         = 32'd0,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'd1532083560,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // The access counter must reach TIMEOUT_CYCLES and is never narrower than
  // 8 bits; the retry counter only needs to hold MAX_RETRIES.
  localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W    = (CNT_BITS > 8) ? CNT_BITS : 8;
  localparam int unsigned RTY_BITS = $clog2(MAX_RETRIES + 1);
  localparam int unsigned RTY_W    = (RTY_BITS > 1) ? RTY_BITS : 1;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [RTY_W-1:0] RETRY_MAX   = RTY_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [RTY_W-1:0] RTY_ONE     = RTY_W'(1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ID      = 2'd2;
  localparam logic [1:0] ERR_TS      = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WT_ID,
    RD_TS,
    WT_TS,
    CHECK,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic               avm_read_q, avm_read_d;
  logic               avm_address_q, avm_address_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [1:0]         err_q, err_d;
  logic [31:0]        id_q, id_d;
  logic [31:0]        ts_q, ts_d;

  logic               in_access;
  logic               timeout_hit;
  logic               cmd_accepted;

  // Next-state and next-output logic. Every registered output has its next
  // value computed here, so the outputs leave the flops glitch-free.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rty_d         = rty_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    err_d         = err_q;
    id_d          = id_q;
    ts_d          = ts_q;

    in_access    = (state_q == RD_ID) || (state_q == WT_ID) ||
                   (state_q == RD_TS) || (state_q == WT_TS);
    timeout_hit  = in_access && (cnt_q == TIMEOUT_VAL);
    cmd_accepted = avm_read_q && !avm_waitrequest;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RD_ID;
          cnt_d         = '0;
          rty_d         = '0;
          avm_address_d = 1'b0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          err_d         = ERR_OK;
        end
      end

      RD_ID, WT_ID, RD_TS, WT_TS: begin
        cnt_d = cnt_q + CNT_ONE;
        // An overrun ends the current attempt regardless of what the slave
        // is doing this cycle; late data from an abandoned access lands in a
        // state that ignores it.
        if (timeout_hit) begin
          avm_address_d = 1'b0;
          if (rty_q < RETRY_MAX) begin
            rty_d   = rty_q + RTY_ONE;
            state_d = RD_ID;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = ERR_TIMEOUT;
          end
        end else begin
          case (state_q)
            RD_ID: begin
              if (cmd_accepted) begin
                state_d = WT_ID;
              end
            end
            WT_ID: begin
              if (avm_readdatavalid) begin
                id_d          = avm_readdata;
                state_d       = RD_TS;
                cnt_d         = '0;
                avm_address_d = 1'b1;
              end
            end
            RD_TS: begin
              if (cmd_accepted) begin
                state_d = WT_TS;
              end
            end
            default: begin
              if (avm_readdatavalid) begin
                ts_d    = avm_readdata;
                state_d = CHECK;
              end
            end
          endcase
        end
      end

      CHECK: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (id_q != EXP_ID) begin
          err_d  = ERR_ID;
          pass_d = 1'b0;
        end else if (ts_q != EXP_TIMESTAMP) begin
          err_d  = ERR_TS;
          pass_d = 1'b0;
        end else begin
          err_d  = ERR_OK;
          pass_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The strobe is derived from where we will be next cycle. Looking at the
    // next counter value lets the strobe fall in the very cycle the counter
    // reaches the limit, so no command can be accepted on a timeout cycle.
    avm_read_d = ((state_d == RD_ID) || (state_d == RD_TS)) &&
                 (cnt_d != TIMEOUT_VAL);
  end

  // Single state register for the whole controller. Reset wins over any
  // request and abandons an access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rty_q         <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= ERR_OK;
      id_q          <= '0;
      ts_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rty_q         <= rty_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_q         <= err_d;
      id_q          <= id_d;
      ts_q          <= ts_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_code    = err_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_irq_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_irq_sysid_checker
//
// Drives irq_sysid_checker against a configurable sysid slave model. A
// transaction-level reference predicts, at each accepted start, when done
// must rise and what the verdict must be. A single compare process then
// checks busy/done/verdict/captured words every cycle. Directed scenarios
// add literal expectations on latency, error codes and command counts.
// ---------------------------------------------------------------------------
module tb_irq_sysid_checker;

  localparam int          TO     = 10;
  localparam int          MR     = 3;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1532083560;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err_code;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int n_checks = 0;
  int n_pass   = 0;

  // Slave configuration, owned by the stimulus process.
  logic [31:0] slv_d0       = 32'd0;
  logic [31:0] slv_d1       = 32'd0;
  int          slv_stall    = 0;
  logic        slv_valid_en = 1'b1;
  int          run_id       = 0;
  int          stray_req    = 0;

  // Slave bookkeeping, owned by the slave process.
  int          acc_id_count = 0;

  // Reference model state, owned by the model process.
  logic        m_active = 1'b0;
  int          m_j      = 0;
  int          m_lat    = 0;
  logic [31:0] m_id     = 32'd0;
  logic [31:0] m_ts     = 32'd0;
  logic        m_pass   = 1'b0;
  logic [1:0]  m_err    = 2'd0;

  // Compare process state.
  logic        chk_en       = 1'b0;
  logic        done_prev    = 1'b0;
  int          done_j       = -1;
  int          stall_cycles = 0;

  irq_sysid_checker #(
    .EXP_ID         (EXP_ID),
    .EXP_TIMESTAMP  (EXP_TS),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRIES    (MR)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .err_code          (err_code),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: actual=%0d expected=%0d (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Configure the slave for one run and pulse start for one cycle. Returns
  // on the falling edge right after the start was sampled.
  task automatic applyStimulus(input logic [31:0] d0, input logic [31:0] d1,
                               input int stall, input logic valid_en);
    slv_d0       = d0;
    slv_d1       = d1;
    slv_stall    = stall;
    slv_valid_en = valid_en;
    run_id++;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Bounded wait for done, then one more edge so the compare process has
  // recorded the rising-edge cycle.
  task automatic waitDone(input int bound, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(name, seen, 1'b1);
    @(negedge clock);
  endtask

  // Sysid slave: zero-wait unless stalling, read data one cycle after the
  // command is accepted. Stalls only the timestamp read, for a per-run
  // number of cycles, and keeps stalling even if the master misbehaves so
  // that a dropped strobe or moved address is visible.
  initial begin
    int stall_budget;
    int stall_rem;
    int seen_run;
    int seen_stray;
    logic acc_pending;
    logic [31:0] acc_data;
    stall_budget = 0;
    stall_rem    = 0;
    seen_run     = 0;
    seen_stray   = 0;
    acc_pending  = 1'b0;
    acc_data     = 32'd0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      if (run_id != seen_run) begin
        seen_run     = run_id;
        stall_budget = slv_stall;
        stall_rem    = 0;
      end
      avm_readdatavalid = 1'b0;
      if (stray_req != seen_stray) begin
        seen_stray        = stray_req;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEADBEEF;
      end else if (acc_pending && slv_valid_en) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = acc_data;
      end
      acc_pending = 1'b0;
      if (stall_rem > 0) begin
        avm_waitrequest = 1'b1;
        stall_rem--;
      end else if (avm_read && avm_address && stall_budget > 0) begin
        avm_waitrequest = 1'b1;
        stall_rem       = stall_budget - 1;
        stall_budget    = 0;
      end else begin
        avm_waitrequest = 1'b0;
        if (avm_read) begin
          acc_pending = 1'b1;
          acc_data    = avm_address ? slv_d1 : slv_d0;
          if (!avm_address) acc_id_count++;
        end
      end
    end
  end

  // Reference model: on an accepted start, work out the verdict and the
  // number of cycles until done straight from the slave configuration.
  // A clean run takes five edges after the start edge, plus any stall
  // cycles; a run that never sees data burns TO+1 cycles per attempt over
  // MR+1 attempts.
  always @(posedge clock) begin
    if (reset) begin
      m_active = 1'b0;
      m_j      = 0;
      m_lat    = 0;
      m_id     = 32'd0;
      m_ts     = 32'd0;
      m_pass   = 1'b0;
      m_err    = 2'd0;
    end else if (start && !(m_active && m_j < m_lat)) begin
      m_active = 1'b1;
      m_j      = 0;
      if (!slv_valid_en) begin
        m_lat  = (MR + 1) * (TO + 1);
        m_err  = 2'd1;
        m_pass = 1'b0;
      end else begin
        m_id  = slv_d0;
        m_ts  = slv_d1;
        m_lat = 5 + slv_stall;
        if (m_id != EXP_ID)      m_err = 2'd2;
        else if (m_ts != EXP_TS) m_err = 2'd3;
        else                     m_err = 2'd0;
        m_pass = (m_err == 2'd0);
      end
    end else if (m_active && m_j < 1000000) begin
      m_j++;
    end
  end

  // Per-cycle comparison of the DUT against the reference model.
  always @(negedge clock) begin
    logic exp_busy;
    logic exp_done;
    if (chk_en) begin
      exp_busy = m_active && (m_j < m_lat);
      exp_done = m_active && (m_j >= m_lat);
      checkOutput("busy", busy, exp_busy);
      checkOutput("done", done, exp_done);
      if (exp_busy) begin
        checkOutput("pass_busy", pass, 1'b0);
        checkOutput("err_busy", err_code, 2'd0);
      end else begin
        checkOutput("pass", pass, exp_done ? m_pass : 1'b0);
        checkOutput("err_code", err_code, exp_done ? m_err : 2'd0);
        checkOutput("avm_read_idle", avm_read, 1'b0);
        checkOutput("id_value", id_value, m_id);
        checkOutput("ts_value", ts_value, m_ts);
        if (!m_active) checkOutput("avm_address_idle", avm_address, 1'b0);
      end
      if (avm_waitrequest) begin
        checkOutput("stall_read_held", avm_read, 1'b1);
        checkOutput("stall_addr_held", avm_address, 1'b1);
        stall_cycles++;
      end
      if (done === 1'b1 && done_prev !== 1'b1) done_j = m_j;
      done_prev = done;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=%0d expected=%0d", 0, 1);
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int stall_base;
    int acc_base;
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);

    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_pass", pass, 1'b0);
    checkOutput("rst_err", err_code, 2'd0);
    checkOutput("rst_read", avm_read, 1'b0);
    checkOutput("rst_addr", avm_address, 1'b0);
    checkOutput("rst_id", id_value, 32'd0);
    checkOutput("rst_ts", ts_value, 32'd0);
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (2) @(negedge clock);

    $display("[TB] matching slave");
    applyStimulus(32'd0, EXP_TS, 0, 1'b1);
    waitDone(50, "match_done_seen");
    checkOutput("match_latency", done_j, 5);
    checkOutput("match_model_lat", m_lat, 5);
    checkOutput("match_pass", pass, 1'b1);
    checkOutput("match_err", err_code, 2'd0);
    checkOutput("match_ts", ts_value, 32'd1532083560);
    repeat (3) @(negedge clock);

    $display("[TB] ID mismatch");
    applyStimulus(32'h0000_0005, EXP_TS, 0, 1'b1);
    waitDone(50, "idmis_done_seen");
    checkOutput("idmis_err", err_code, 2'd2);
    checkOutput("idmis_pass", pass, 1'b0);
    checkOutput("idmis_id", id_value, 32'd5);
    repeat (2) @(negedge clock);

    $display("[TB] stalled timestamp read, wrong timestamp");
    stall_base = stall_cycles;
    applyStimulus(32'd0, 32'd0, 4, 1'b1);
    waitDone(60, "stall_done_seen");
    checkOutput("stall_err", err_code, 2'd3);
    checkOutput("stall_latency", done_j, 9);
    checkOutput("stall_cycles", stall_cycles - stall_base, 4);
    repeat (2) @(negedge clock);

    $display("[TB] start while busy");
    applyStimulus(32'd0, EXP_TS, 0, 1'b1);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone(50, "mid_done_seen");
    checkOutput("mid_latency", done_j, 5);
    checkOutput("mid_pass", pass, 1'b1);
    repeat (4) @(negedge clock);

    $display("[TB] silent slave, retries then timeout");
    acc_base = acc_id_count;
    applyStimulus(32'h0000_1234, 32'h0000_5678, 0, 1'b0);
    waitDone(200, "to_done_seen");
    checkOutput("to_err", err_code, 2'd1);
    checkOutput("to_pass", pass, 1'b0);
    checkOutput("to_latency", done_j, 44);
    checkOutput("to_model_lat", m_lat, 44);
    checkOutput("to_id_cmds", acc_id_count - acc_base, 4);
    repeat (2) @(negedge clock);

    $display("[TB] reset during timestamp wait");
    applyStimulus(32'd0, EXP_TS, 0, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    stray_req++;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_read", avm_read, 1'b0);
    checkOutput("abort_addr", avm_address, 1'b0);
    checkOutput("abort_id", id_value, 32'd0);
    checkOutput("abort_ts", ts_value, 32'd0);
    repeat (3) @(negedge clock);
    checkOutput("stray_id", id_value, 32'd0);
    checkOutput("stray_ts", ts_value, 32'd0);
    applyStimulus(32'd0, EXP_TS, 0, 1'b1);
    waitDone(50, "clean_done_seen");
    checkOutput("clean_latency", done_j, 5);
    checkOutput("clean_pass", pass, 1'b1);
    checkOutput("clean_ts", ts_value, 32'd1532083560);
    repeat (2) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
